// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/flush controller.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned NumGpr = 16;
  localparam int unsigned CntW   = 2;
  localparam int unsigned RegX0  = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StIcfl  = 2'd2,
    StRedir = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// Per-GPR in-flight writer counters with RAW and saturation hazard lookup.
module pipe_hazard_ctrl_hazard_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_GPR = NumGpr,
  parameter int unsigned CNT_W   = CntW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_en,
  input  logic [$clog2(NUM_GPR)-1:0] issue_rd,
  input  logic                       retire_en,
  input  logic [$clog2(NUM_GPR)-1:0] retire_rd,
  input  logic                       rollback_en,
  input  logic [$clog2(NUM_GPR)-1:0] rollback_rd,
  input  logic                       id_valid,
  input  logic [$clog2(NUM_GPR)-1:0] rs1,
  input  logic                       rs1_used,
  input  logic [$clog2(NUM_GPR)-1:0] rs2,
  input  logic                       rs2_used,
  input  logic [$clog2(NUM_GPR)-1:0] rd,
  input  logic                       rd_we,
  output logic                       raw_hazard,
  output logic                       sat_hazard,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(NUM_GPR);
  localparam logic [AW-1:0] X0 = AW'(RegX0);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q [NUM_GPR];
  logic [CNT_W-1:0] cnt_d [NUM_GPR];
  logic [NUM_GPR-1:0] underflow;
  logic [NUM_GPR-1:0] nonzero;

  for (genvar g = 0; g < NUM_GPR; g++) begin : g_reg
    assign nonzero[g] = (cnt_q[g] != '0);

    if (g == RegX0) begin : g_x0
      assign cnt_d[g]     = '0;
      assign underflow[g] = 1'b0;
    end else begin : g_track
      logic             inc;
      logic             dec_wb;
      logic             dec_rb;
      logic [CNT_W+1:0] sum;
      logic [CNT_W+1:0] sub;
      logic [CNT_W+1:0] diff;

      assign inc    = issue_en && (issue_rd == AW'(g));
      assign dec_wb = retire_en && (retire_rd == AW'(g));
      assign dec_rb = rollback_en && (rollback_rd == AW'(g));

      // Issue, retire and rollback all land on the same edge as one net delta.
      assign sum          = {2'b00, cnt_q[g]} + (CNT_W+2)'(inc);
      assign sub          = (CNT_W+2)'(dec_wb) + (CNT_W+2)'(dec_rb);
      assign diff         = sum - sub;
      assign underflow[g] = (sum < sub);
      assign cnt_d[g]     = underflow[g] ? '0 : diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_GPR; i++) begin
      if (reset) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    raw_hazard = id_valid &&
                 ((rs1_used && (rs1 != X0) && (cnt_q[rs1] != '0)) ||
                  (rs2_used && (rs2 != X0) && (cnt_q[rs2] != '0)));
    sat_hazard = rd_we && (cnt_q[rd] == CntMax);
    busy       = |nonzero;
  end

  assert property (@(posedge clk) disable iff (reset) underflow == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and flush controller: RAW scoreboard stall, redirect flushes, fence.i sequencing.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_GPR = NumGpr,
  parameter int unsigned CNT_W   = CntW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [$clog2(NUM_GPR)-1:0] id_rs1,
  input  logic [$clog2(NUM_GPR)-1:0] id_rs2,
  input  logic                       id_rs1_used,
  input  logic                       id_rs2_used,
  input  logic [$clog2(NUM_GPR)-1:0] id_rd,
  input  logic                       id_rd_we,
  input  logic                       idex_in_ready,
  output logic                       id_stall,
  input  logic                       idex_valid,
  input  logic [$clog2(NUM_GPR)-1:0] idex_rd,
  input  logic                       idex_rd_we,
  input  logic                       wb_valid,
  input  logic [$clog2(NUM_GPR)-1:0] wb_rd,
  input  logic                       wb_we,
  input  logic                       exe_redirect,
  input  logic                       exe_fence_i,
  input  logic [31:0]                exe_redirect_pc,
  input  logic                       lsu_busy,
  output logic                       icache_flush,
  input  logic                       icache_flush_done,
  output logic                       flush_ifid,
  output logic                       flush_idex,
  output logic                       pc_redirect_valid,
  output logic [31:0]                pc_redirect_pc,
  output logic                       sb_busy,
  output logic [31:0]                perf_raw_stall_cnt,
  output logic [31:0]                perf_flush_cnt
);

  localparam int unsigned AW = $clog2(NUM_GPR);
  localparam logic [AW-1:0] X0 = AW'(RegX0);

  ctrl_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        icache_flush_q;
  logic        raw_hazard;
  logic        sat_hazard;
  logic        fire;
  logic        issue_en;
  logic        retire_en;
  logic        rollback_en;

  assign id_stall    = raw_hazard || sat_hazard || (state_q != StIdle) || flush_idex;
  assign fire        = id_valid && !id_stall && idex_in_ready;
  assign issue_en    = fire && id_rd_we && (id_rd != X0);
  assign retire_en   = wb_valid && wb_we && (wb_rd != X0);
  // Flushed ID/EXE contents never reach WB, so their reservation is returned here.
  assign rollback_en = flush_idex && idex_valid && idex_rd_we && (idex_rd != X0);

  pipe_hazard_ctrl_hazard_scoreboard #(
    .NUM_GPR (NUM_GPR),
    .CNT_W   (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_en    (issue_en),
    .issue_rd    (id_rd),
    .retire_en   (retire_en),
    .retire_rd   (wb_rd),
    .rollback_en (rollback_en),
    .rollback_rd (idex_rd),
    .id_valid    (id_valid),
    .rs1         (id_rs1),
    .rs1_used    (id_rs1_used),
    .rs2         (id_rs2),
    .rs2_used    (id_rs2_used),
    .rd          (id_rd),
    .rd_we       (id_rd_we),
    .raw_hazard  (raw_hazard),
    .sat_hazard  (sat_hazard),
    .busy        (sb_busy)
  );

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    flush_ifid        = 1'b0;
    flush_idex        = 1'b0;
    pc_redirect_valid = 1'b0;
    pc_redirect_pc    = '0;
    unique case (state_q)
      StIdle: begin
        // fence.i takes priority; its redirect is deferred until the icache is clean.
        if (exe_fence_i) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          pc_d       = exe_redirect_pc;
          state_d    = StDrain;
        end else if (exe_redirect) begin
          flush_ifid        = 1'b1;
          flush_idex        = 1'b1;
          pc_redirect_valid = 1'b1;
          pc_redirect_pc    = exe_redirect_pc;
        end
      end
      StDrain: begin
        if (!sb_busy && !lsu_busy) begin
          state_d = StIcfl;
        end
      end
      StIcfl: begin
        if (icache_flush_done) begin
          state_d = StRedir;
        end
      end
      StRedir: begin
        pc_redirect_valid = 1'b1;
        pc_redirect_pc    = pc_q;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      pc_q           <= '0;
      icache_flush_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      icache_flush_q <= (state_d == StIcfl);
    end
  end

  assign icache_flush = icache_flush_q;

  assert property (@(posedge clk) disable iff (reset)
    (state_q != StIdle) |-> !(exe_redirect || exe_fence_i));

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_raw_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_raw_q   <= '0;
      perf_flush_q <= '0;
    end else begin
      if (id_valid && raw_hazard) begin
        perf_raw_q <= perf_raw_q + 32'd1;
      end
      if (flush_idex) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_raw_stall_cnt = perf_raw_q;
  assign perf_flush_cnt     = perf_flush_q;
`else
  assign perf_raw_stall_cnt = '0;
  assign perf_flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed steps, then random traffic against an in-flight-writer model.
module tb_pipe_hazard_ctrl;

  localparam int MaxInflight   = 3;
  localparam int ModeIdle      = 0;
  localparam int ModeWaitDrain = 1;
  localparam int ModeWaitInval = 2;
  localparam int ModeRedirect  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [3:0]  id_rs1, id_rs2;
  logic        id_rs1_used, id_rs2_used;
  logic [3:0]  id_rd;
  logic        id_rd_we;
  logic        idex_in_ready;
  logic        id_stall;
  logic        idex_valid;
  logic [3:0]  idex_rd;
  logic        idex_rd_we;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        wb_we;
  logic        exe_redirect;
  logic        exe_fence_i;
  logic [31:0] exe_redirect_pc;
  logic        lsu_busy;
  logic        icache_flush;
  logic        icache_flush_done;
  logic        flush_ifid, flush_idex;
  logic        pc_redirect_valid;
  logic [31:0] pc_redirect_pc;
  logic        sb_busy;
  logic [31:0] perf_raw_stall_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .id_valid           (id_valid),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .id_rs1_used        (id_rs1_used),
    .id_rs2_used        (id_rs2_used),
    .id_rd              (id_rd),
    .id_rd_we           (id_rd_we),
    .idex_in_ready      (idex_in_ready),
    .id_stall           (id_stall),
    .idex_valid         (idex_valid),
    .idex_rd            (idex_rd),
    .idex_rd_we         (idex_rd_we),
    .wb_valid           (wb_valid),
    .wb_rd              (wb_rd),
    .wb_we              (wb_we),
    .exe_redirect       (exe_redirect),
    .exe_fence_i        (exe_fence_i),
    .exe_redirect_pc    (exe_redirect_pc),
    .lsu_busy           (lsu_busy),
    .icache_flush       (icache_flush),
    .icache_flush_done  (icache_flush_done),
    .flush_ifid         (flush_ifid),
    .flush_idex         (flush_idex),
    .pc_redirect_valid  (pc_redirect_valid),
    .pc_redirect_pc     (pc_redirect_pc),
    .sb_busy            (sb_busy),
    .perf_raw_stall_cnt (perf_raw_stall_cnt),
    .perf_flush_cnt     (perf_flush_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: writers not yet retired live either in the ID/EXE slot or in the downstream queue.
  logic [3:0]  pend[$];
  bit          slot_v, slot_we;
  logic [3:0]  slot_rd;
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_perf_raw, m_perf_flush;
  bit          do_wb;

  logic        obs_stall, obs_ifid, obs_idex, obs_pcv, obs_busy, obs_ic;
  logic [31:0] obs_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int inflight(input logic [3:0] r);
    int n = 0;
    if (r == 4'd0) return 0;
    foreach (pend[i]) if (pend[i] == r) n++;
    if (slot_v && slot_we && slot_rd == r) n++;
    return n;
  endfunction

  task automatic set_id(input bit v, input logic [3:0] rs1, input bit u1, input logic [3:0] rs2,
                        input bit u2, input logic [3:0] rd, input bit we);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we;
  endtask

  // One clock: drive pipeline glue, compare at negedge, advance the model at posedge.
  task automatic tick(input bit chk);
    bit          e_raw, e_sat, e_fence, e_redir, e_flush, e_stall, e_pcv, e_busy, fired;
    logic [31:0] e_pc;
    idex_valid = slot_v; idex_rd = slot_rd; idex_rd_we = slot_we;
    if (do_wb && pend.size() > 0) begin
      wb_valid = 1'b1; wb_we = 1'b1; wb_rd = pend[0];
    end else begin
      wb_valid = 1'b0; wb_we = 1'b0; wb_rd = 4'd0;
    end
    @(negedge clk);
    e_raw   = id_valid && ((id_rs1_used && id_rs1 != 0 && inflight(id_rs1) > 0) ||
                           (id_rs2_used && id_rs2 != 0 && inflight(id_rs2) > 0));
    e_sat   = id_rd_we && (inflight(id_rd) >= MaxInflight);
    e_fence = (m_mode == ModeIdle) && exe_fence_i;
    e_redir = (m_mode == ModeIdle) && exe_redirect && !exe_fence_i;
    e_flush = e_fence || e_redir;
    e_stall = e_raw || e_sat || (m_mode != ModeIdle) || e_flush;
    e_pcv   = e_redir || (m_mode == ModeRedirect);
    e_pc    = e_redir ? exe_redirect_pc : m_pc;
    e_busy  = (pend.size() > 0) || (slot_v && slot_we && slot_rd != 0);
    obs_stall = id_stall; obs_ifid = flush_ifid; obs_idex = flush_idex;
    obs_pcv = pc_redirect_valid; obs_pc = pc_redirect_pc; obs_busy = sb_busy;
    obs_ic = icache_flush;
    if (chk) begin
      check("id_stall", 32'(id_stall), 32'(e_stall));
      check("flush_ifid", 32'(flush_ifid), 32'(e_flush));
      check("flush_idex", 32'(flush_idex), 32'(e_flush));
      check("pc_redirect_valid", 32'(pc_redirect_valid), 32'(e_pcv));
      if (e_pcv) check("pc_redirect_pc", pc_redirect_pc, e_pc);
      check("sb_busy", 32'(sb_busy), 32'(e_busy));
      check("icache_flush", 32'(icache_flush), 32'(m_mode == ModeWaitInval));
`ifdef PIPE_HAZARD_PERF_EN
      check("perf_raw", perf_raw_stall_cnt, m_perf_raw);
      check("perf_flush", perf_flush_cnt, m_perf_flush);
`else
      check("perf_raw", perf_raw_stall_cnt, 32'd0);
      check("perf_flush", perf_flush_cnt, 32'd0);
`endif
    end
    @(posedge clk);
    if (reset) begin
      pend.delete();
      slot_v = 1'b0; slot_we = 1'b0; slot_rd = 4'd0;
      m_mode = ModeIdle; m_pc = '0; m_perf_raw = '0; m_perf_flush = '0;
    end else begin
      fired = id_valid && !e_stall && idex_in_ready;
      if (wb_valid) void'(pend.pop_front());
      if (!e_flush && slot_v && slot_we && slot_rd != 0) pend.push_back(slot_rd);
      slot_v = fired; slot_we = fired && id_rd_we; slot_rd = id_rd;
      case (m_mode)
        ModeIdle:      if (e_fence) begin m_mode = ModeWaitDrain; m_pc = exe_redirect_pc; end
        ModeWaitDrain: if (!e_busy && !lsu_busy) m_mode = ModeWaitInval;
        ModeWaitInval: if (icache_flush_done) m_mode = ModeRedirect;
        default:       m_mode = ModeIdle;
      endcase
      m_perf_raw   = m_perf_raw + 32'(e_raw);
      m_perf_flush = m_perf_flush + 32'(e_flush);
    end
    #1;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0);
    exe_redirect = 0; exe_fence_i = 0; lsu_busy = 0; icache_flush_done = 0; do_wb = 1;
    for (int k = 0; k < 20 && (pend.size() != 0 || slot_v); k++) tick(1);
    do_wb = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    reset = 1; set_id(0, 0, 0, 0, 0, 0, 0); idex_in_ready = 1;
    exe_redirect = 0; exe_fence_i = 0; exe_redirect_pc = '0; lsu_busy = 0;
    icache_flush_done = 0; do_wb = 0;
    slot_v = 0; slot_we = 0; slot_rd = 0; m_mode = ModeIdle; m_pc = '0;
    m_perf_raw = '0; m_perf_flush = '0;
    tick(0); tick(1);
    reset = 0; tick(1);
    check("rst_stall", 32'(obs_stall), 32'd0);
    check("rst_flush", 32'(obs_ifid | obs_idex), 32'd0);
    check("rst_pcv", 32'(obs_pcv), 32'd0);
    check("rst_pc", obs_pc, 32'd0);
    check("rst_busy", 32'(obs_busy), 32'd0);
    check("rst_icache", 32'(obs_ic), 32'd0);

    // RAW on x5 held until WB commits it
    set_id(1, 0, 0, 0, 0, 5, 1); tick(1);
    set_id(1, 5, 1, 0, 0, 6, 1); tick(1);
    check("t1_raw_stall", 32'(obs_stall), 32'd1);
    tick(1); tick(1);
    check("t1_hold", 32'(obs_stall), 32'd1);
    do_wb = 1; tick(1);
    do_wb = 0; tick(1);
    check("t1_release", 32'(obs_stall), 32'd0);
    drain();

    // Same-edge issue and retire on x3; saturation on x7
    set_id(1, 0, 0, 0, 0, 3, 1); tick(1);
    set_id(0, 0, 0, 0, 0, 0, 0); tick(1);
    set_id(1, 0, 0, 0, 0, 3, 1); do_wb = 1; tick(1);
    do_wb = 0; set_id(1, 3, 1, 0, 0, 0, 0); tick(1);
    check("t2_cnt_kept", 32'(obs_stall), 32'd1);
    check("t2_busy", 32'(obs_busy), 32'd1);
    drain();
    set_id(1, 0, 0, 0, 0, 7, 1); tick(1); tick(1); tick(1);
    check("t2_third_issue", 32'(obs_stall), 32'd0);
    tick(1);
    check("t2_sat", 32'(obs_stall), 32'd1);
    drain();

    // Redirect with a writer in ID/EXE
    set_id(1, 0, 0, 0, 0, 9, 1); tick(1);
    set_id(0, 0, 0, 0, 0, 0, 0); exe_redirect = 1; exe_redirect_pc = 32'h8000_0040; tick(1);
    check("t3_ifid", 32'(obs_ifid), 32'd1);
    check("t3_idex", 32'(obs_idex), 32'd1);
    check("t3_pcv", 32'(obs_pcv), 32'd1);
    check("t3_pc", obs_pc, 32'h8000_0040);
    exe_redirect = 0; tick(1);
    check("t3_rollback", 32'(obs_busy), 32'd0);

    // fence.i with the LSU busy for a while
    exe_fence_i = 1; exe_redirect_pc = 32'h8000_0104; lsu_busy = 1; tick(1);
    check("t4_flush", 32'(obs_idex), 32'd1);
    check("t4_no_redirect", 32'(obs_pcv), 32'd0);
    exe_fence_i = 0;
    repeat (5) tick(1);
    check("t4_drain_hold", 32'(obs_ic), 32'd0);
    check("t4_drain_stall", 32'(obs_stall), 32'd1);
    lsu_busy = 0; tick(1);
    check("t4_pre_icfl", 32'(obs_ic), 32'd0);
    tick(1);
    check("t4_icfl", 32'(obs_ic), 32'd1);
    icache_flush_done = 1; tick(1);
    check("t4_done_cycle", 32'(obs_ic), 32'd1);
    icache_flush_done = 0; tick(1);
    check("t4_redir", 32'(obs_pcv), 32'd1);
    check("t4_redir_pc", obs_pc, 32'h8000_0104);
    check("t4_ic_low", 32'(obs_ic), 32'd0);
    tick(1);
    check("t4_redir_once", 32'(obs_pcv), 32'd0);

    // Simultaneous redirect and fence.i, then reset during the icache flush
    exe_redirect = 1; exe_fence_i = 1; exe_redirect_pc = 32'h8000_0200; tick(1);
    check("t5_fence_wins", 32'(obs_pcv), 32'd0);
    check("t5_flush", 32'(obs_ifid), 32'd1);
    exe_redirect = 0; exe_fence_i = 0; tick(1);
    tick(1);
    check("t5_icfl", 32'(obs_ic), 32'd1);
    reset = 1; tick(1);
    reset = 0; tick(1);
    check("t5_rst_ic", 32'(obs_ic), 32'd0);
    check("t5_rst_idle", 32'(obs_stall), 32'd0);

    // x0 is never a hazard
    set_id(1, 0, 1, 0, 1, 0, 1);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("t6_x0_stall", 32'(obs_stall), 32'd0);
    end
    check("t6_x0_busy", 32'(obs_busy), 32'd0);
    drain();

    for (int n = 0; n < 3000; n++) begin
      int r;
      reset = ($urandom_range(0, 999) < 3);
      set_id($urandom_range(0, 9) < 7, 4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)));
      idex_in_ready = ($urandom_range(0, 99) < 85);
      do_wb = ($urandom_range(0, 9) < 4);
      lsu_busy = ($urandom_range(0, 9) < 3);
      exe_redirect = 0; exe_fence_i = 0;
      exe_redirect_pc = $urandom() & 32'hffff_fffc;
      if (!reset && m_mode == ModeIdle) begin
        r = $urandom_range(0, 99);
        exe_redirect = (r < 5);
        exe_fence_i  = (r >= 3 && r < 6);
      end
      icache_flush_done = !reset && (m_mode == ModeWaitInval) && ($urandom_range(0, 3) == 0);
      tick(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
